fp_accumulator: RTL and testbench

- Sequential FP32 accumulator directly downstream of the floating-point multiplier.
- Consumes registered products over a valid/ready handshake and adds each one into a running single-precision sum.
- Uses a multi-cycle align/add/normalise FSM and truncation rounding.
- Number conventions match the multiplier: denormals flush to zero, overflow saturates to infinity with a zero fraction.

---
 rtl/fp_accumulator_if.sv | 11 +
 rtl/fp_accumulator.sv | 150 +++++++++++++++
 tb/tb_fp_accumulator.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_accumulator_if.sv
// fp_accumulator_if: operand handshake bundle between the multiplier and the accumulator
// Signals: in_valid/in_data driven by the producer, in_ready returned by the accumulator
interface fp_accumulator_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_data;
  modport master (output in_valid, output in_data, input in_ready);
  modport slave (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fp_accumulator.sv
// fp_accumulator: sequential FP32 accumulator, align/add/normalise FSM with truncation rounding
// Ports: clk, rst (async active-low), clear (sync clear/abort), in_if (operand handshake),
//        acc_out (running sum), out_valid (one-cycle update pulse), busy (FSM not idle),
//        count (terms accumulated, saturating)
module fp_accumulator #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  fp_accumulator_if.slave  in_if,
  output logic [XLEN-1:0]  acc_out,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] count
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] opnd, opnd_n, acc_n;
  logic [CNT_W-1:0] count_n;
  logic [24:0] mant, mant_n, mb, mb_n;
  logic [7:0] exp_r, exp_n;
  logic sign, sign_n, sb, sb_n, nan, nan_n, ov_n;
  logic [7:0] ea, eb, d;
  logic [23:0] ua, ub, ua_s, ub_s;
  logic a_ge, a_inf, b_inf, same, a_gt, rsign;
  logic [24:0] sum;
  assign ea    = acc_out[30:23];
  assign eb    = opnd[30:23];
  assign a_inf = ea == 8'hFF;
  assign b_inf = eb == 8'hFF;
  assign ua    = ea == 8'd0 ? 24'd0 : {1'b1, acc_out[22:0]};
  assign ub    = eb == 8'd0 ? 24'd0 : {1'b1, opnd[22:0]};
  assign a_ge  = ea >= eb;
  assign d     = a_ge ? ea - eb : eb - ea;
  // the smaller-exponent mantissa is truncated; a distance of 24+ leaves nothing
  assign ua_s  = a_ge ? ua : (d > 8'd23 ? 24'd0 : ua >> d);
  assign ub_s  = a_ge ? (d > 8'd23 ? 24'd0 : ub >> d) : ub;
  assign same  = sign == sb;
  assign a_gt  = mant > mb;
  assign sum   = same ? mant + mb : (a_gt ? mant - mb : mb - mant);
  assign rsign = (same || a_gt) ? sign : sb;
  assign in_if.in_ready = state == IDLE && !clear;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    opnd_n  = opnd;
    acc_n   = acc_out;
    count_n = count;
    mant_n  = mant;
    mb_n    = mb;
    exp_n   = exp_r;
    sign_n  = sign;
    sb_n    = sb;
    nan_n   = nan;
    ov_n    = 1'b0;
    if (clear) begin
      state_n = IDLE;
      acc_n   = '0;
      count_n = '0;
      nan_n   = 1'b0;
    end else begin
      case (state)
        IDLE: if (in_if.in_valid) begin
          opnd_n  = in_if.in_data;
          state_n = ALIGN;
        end
        ALIGN: begin
          state_n = DONE;
          if (nan)
            {sign_n, exp_n, mant_n} = {1'b0, 8'hFF, 25'h0400000};
          else if (a_inf && b_inf && acc_out[31] != opnd[31]) begin
            {sign_n, exp_n, mant_n} = {1'b0, 8'hFF, 25'h0400000};
            nan_n = 1'b1;
          end else if (b_inf)
            {sign_n, exp_n, mant_n} = {opnd[31], 8'hFF, 25'h0};
          else if (a_inf)
            {sign_n, exp_n, mant_n} = {acc_out[31], ea, 2'b0, acc_out[22:0]};
          else begin
            state_n = ADD;
            sign_n  = acc_out[31];
            sb_n    = opnd[31];
            exp_n   = a_ge ? ea : eb;
            mant_n  = {1'b0, ua_s};
            mb_n    = {1'b0, ub_s};
          end
        end
        ADD: begin
          sign_n = rsign;
          state_n = DONE;
          if (sum == 25'd0)
            {sign_n, exp_n, mant_n} = '0;
          else if (sum[24]) begin
            mant_n = sum >> 1;
            exp_n  = exp_r + 8'd1;
            if (exp_r == 8'hFE) mant_n = '0;
          end else begin
            mant_n  = sum;
            state_n = sum[23] ? DONE : NORM;
          end
        end
        NORM: begin
          // leaving exp at 0 would be a denormal, which flushes to +0
          if (exp_r == 8'd1) begin
            {sign_n, exp_n, mant_n} = '0;
            state_n = DONE;
          end else begin
            mant_n  = mant << 1;
            exp_n   = exp_r - 8'd1;
            state_n = mant[22] ? DONE : NORM;
          end
        end
        DONE: begin
          acc_n   = {sign, exp_r, mant[22:0]};
          count_n = &count ? count : count + 1'b1;
          ov_n    = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      opnd      <= '0;
      acc_out   <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      mant      <= '0;
      mb        <= '0;
      exp_r     <= '0;
      sign      <= 1'b0;
      sb        <= 1'b0;
      nan       <= 1'b0;
    end else begin
      state     <= state_n;
      opnd      <= opnd_n;
      acc_out   <= acc_n;
      count     <= count_n;
      out_valid <= ov_n;
      mant      <= mant_n;
      mb        <= mb_n;
      exp_r     <= exp_n;
      sign      <= sign_n;
      sb        <= sb_n;
      nan       <= nan_n;
    end
endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: directed vector table, clear/reset corner sequences and randomized model checks
module tb_fp_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic [31:0] acc_out;
  logic out_valid, busy;
  logic [15:0] count;
  int pass_cnt = 0;
  int total = 0;
  fp_accumulator_if #(.XLEN(32)) bus ();
  fp_accumulator #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_if(bus),
    .acc_out(acc_out), .out_valid(out_valid), .busy(busy), .count(count)
  );
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  typedef struct {
    logic        clr;
    logic [31:0] x;
    logic [31:0] acc;
    int          lat;
    int          cnt;
  } vec_t;
  vec_t vec[15];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic accept(input logic [31:0] x);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = x;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic do_op(input logic [31:0] x, output int lat);
    accept(x);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask
  // reference: exact integer alignment with truncation, then normalise by plain arithmetic
  function automatic void model(input logic [31:0] a, input logic [31:0] b, inout logic nan,
                                output logic [31:0] r, output int lat);
    int ea, eb, e;
    longint ma, mb, s, m;
    logic sa;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    lat = 2;
    if (nan) begin r = 32'h7FC00000; return; end
    if (ea == 255 && eb == 255 && a[31] != b[31]) begin nan = 1'b1; r = 32'h7FC00000; return; end
    if (eb == 255) begin r = {b[31], 8'hFF, 23'h0}; return; end
    if (ea == 255) begin r = a; return; end
    ma = ea == 0 ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
    mb = eb == 0 ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
    e = ea > eb ? ea : eb;
    ma = (e - ea >= 24) ? 0 : ma >> (e - ea);
    mb = (e - eb >= 24) ? 0 : mb >> (e - eb);
    s = (a[31] ? -ma : ma) + (b[31] ? -mb : mb);
    lat = 3;
    if (s == 0) begin r = 32'h0; return; end
    sa = s < 0;
    m = sa ? -s : s;
    if (m >= (longint'(1) << 24)) begin
      m = m >> 1;
      e++;
      if (e == 255) begin r = {sa, 8'hFF, 23'h0}; return; end
    end
    while (m < (longint'(1) << 23)) begin
      m = m << 1;
      e--;
      lat++;
      if (e == 0) begin r = 32'h0; return; end
    end
    r = {sa, 8'(e), m[22:0]};
  endfunction
  function automatic logic [31:0] rand_op(input logic [31:0] acc);
    int r;
    logic s;
    logic [22:0] f;
    r = int'($urandom_range(0, 19));
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    if (r == 0) return {s, 31'h0};
    if (r == 1) return {s, 8'h00, f};
    if (r == 2) return {s, 8'hFF, 23'h0};
    if (r == 3) return {s, 31'h7F7FFFFF};
    if (r == 4) return acc ^ 32'h80000000;
    if (r <= 7) return {~acc[31], acc[30:23], f};
    if (r == 8) return {~acc[31], acc[30:23] - 8'd1, f};
    return {s, 8'($urandom_range(100, 150)), f};
  endfunction
  initial begin
    int lat, elat, seen;
    logic [31:0] m_acc, x, r;
    logic m_nan;
    int m_cnt;
    vec = '{
      '{1'b1, 32'h3F800000, 32'h3F800000, 3, 1},
      '{1'b0, 32'h40000000, 32'h40400000, 3, 2},
      '{1'b0, 32'hC0400000, 32'h00000000, 3, 3},
      '{1'b0, 32'h3F800000, 32'h3F800000, 3, 4},
      '{1'b0, 32'hBF000000, 32'h3F000000, 4, 5},
      '{1'b1, 32'h3F800000, 32'h3F800000, 3, 1},
      '{1'b0, 32'h33800000, 32'h3F800000, 3, 2},
      '{1'b1, 32'h3F800000, 32'h3F800000, 3, 1},
      '{1'b0, 32'h34000000, 32'h3F800001, 3, 2},
      '{1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 3, 1},
      '{1'b0, 32'h7F7FFFFF, 32'h7F800000, 3, 2},
      '{1'b0, 32'hFF800000, 32'h7FC00000, 2, 3},
      '{1'b0, 32'h3F800000, 32'h7FC00000, 2, 4},
      '{1'b1, 32'h3F800000, 32'h3F800000, 3, 1},
      '{1'b0, 32'hBF7FFFFF, 32'h34000000, 26, 2}
    };
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst acc", acc_out, 32'h0);
    check("rst cnt", 32'(count), 32'h0);
    check("rst ov", 32'(out_valid), 32'h0);
    check("rst rdy", 32'(bus.in_ready), 32'h1);
    check("rst busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    foreach (vec[i]) begin
      if (vec[i].clr) do_clear();
      do_op(vec[i].x, lat);
      check($sformatf("vec%0d acc", i), acc_out, vec[i].acc);
      check($sformatf("vec%0d lat", i), 32'(lat), 32'(vec[i].lat));
      check($sformatf("vec%0d cnt", i), 32'(count), 32'(vec[i].cnt));
    end
    do_clear();
    check("clr acc", acc_out, 32'h0);
    check("clr cnt", 32'(count), 32'h0);
    @(negedge clk);
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h3F800000;
    #1;
    check("clr+valid rdy", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clr+valid busy", 32'(busy), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check("clr+valid cnt", 32'(count), 32'h0);
    check("clr+valid acc", acc_out, 32'h0);
    do_op(32'h3F800000, lat);
    accept(32'hBF7FFFFF);
    repeat (5) @(posedge clk);
    #1;
    check("norm busy", 32'(busy), 32'h1);
    do_clear();
    check("norm clr busy", 32'(busy), 32'h0);
    check("norm clr acc", acc_out, 32'h0);
    check("norm clr cnt", 32'(count), 32'h0);
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("norm clr no ov", 32'(seen), 32'h0);
    do_op(32'h3F800000, lat);
    accept(32'hBF7FFFFF);
    repeat (5) @(posedge clk);
    #1;
    check("rst norm busy", 32'(busy), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2 acc", acc_out, 32'h0);
    check("rst2 cnt", 32'(count), 32'h0);
    check("rst2 ov", 32'(out_valid), 32'h0);
    check("rst2 rdy", 32'(bus.in_ready), 32'h1);
    check("rst2 busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    m_acc = 32'h0;
    m_nan = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      if (((m_nan || m_acc[30:23] == 8'hFF) && $urandom_range(0, 2) == 0) || $urandom_range(0, 24) == 0) begin
        do_clear();
        m_acc = 32'h0;
        m_nan = 1'b0;
        m_cnt = 0;
      end
      x = rand_op(m_acc);
      model(m_acc, x, m_nan, r, elat);
      do_op(x, lat);
      m_acc = r;
      m_cnt++;
      check($sformatf("rnd%0d acc (%h)", i, x), acc_out, m_acc);
      check($sformatf("rnd%0d lat", i), 32'(lat), 32'(elat));
      check($sformatf("rnd%0d cnt", i), 32'(count), 32'(m_cnt));
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
